// File: rtl/kws_spike_decoder.sv
// Keyword-spotting spike decoder: counts output-layer spikes per window and votes a class.
// Optional hidden-layer activity total is built only when DECODER_ACTIVITY_EN is defined.
module kws_spike_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        spike_valid,
   input  logic [1:0]  output_spikes,
   input  logic [7:0]  output_spikes_layer1,
   input  logic [7:0]  window_len,
   input  logic [7:0]  min_count,
   input  logic        decision_ready,
   output logic        decision_valid,
   output logic [1:0]  decision_class,
   output logic [7:0]  count0,
   output logic [7:0]  count1,
   output logic        busy,
`ifdef DECODER_ACTIVITY_EN
   output logic [11:0] activity_count,
`endif
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, HOLD} state_t;

   state_t     state, state_next;
   logic [7:0] acc0, acc1;
   logic [8:0] steps, win;
   logic [7:0] min_lat;
   logic       start, take;
   logic [1:0] cls;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      take       = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_next = ACCUM;
               start      = 1'b1;
            end
         end
         ACCUM: begin
            if (!enable) begin
               state_next = IDLE;
            end else if (spike_valid) begin
               take = 1'b1;
               if (steps + 9'd1 == win) state_next = DECIDE;
            end
         end
         DECIDE: state_next = HOLD;
         HOLD: begin
            if (decision_ready) begin
               if (enable) begin
                  state_next = ACCUM;
                  start      = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A tie only counts when both classes actually fired.
   always_comb begin
      cls = 2'b00;
      if (acc0 > acc1 && acc0 >= min_lat)
         cls = 2'b01;
      else if (acc1 > acc0 && acc1 >= min_lat)
         cls = 2'b10;
      else if (acc0 == acc1 && acc0 >= min_lat && acc0 != 8'd0)
         cls = 2'b11;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc0           <= 8'd0;
         acc1           <= 8'd0;
         steps          <= 9'd0;
         win            <= 9'd0;
         min_lat        <= 8'd0;
         count0         <= 8'd0;
         count1         <= 8'd0;
         decision_class <= 2'b00;
         overrun        <= 1'b0;
      end else begin
         if (start) begin
            acc0    <= 8'd0;
            acc1    <= 8'd0;
            steps   <= 9'd0;
            win     <= (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
            min_lat <= min_count;
         end else if (take) begin
            if (output_spikes[0] && acc0 != 8'hFF) acc0 <= acc0 + 8'd1;
            if (output_spikes[1] && acc1 != 8'hFF) acc1 <= acc1 + 8'd1;
            steps <= steps + 9'd1;
         end
         if (state == DECIDE) begin
            count0         <= acc0;
            count1         <= acc1;
            decision_class <= cls;
         end
         if (spike_valid && (state == DECIDE || state == HOLD))
            overrun <= 1'b1;
      end
   end

   assign decision_valid = (state == HOLD);
   assign busy           = (state != IDLE);

`ifdef DECODER_ACTIVITY_EN
   logic [11:0] act;
   logic [3:0]  pop;
   logic [12:0] act_sum;

   always_comb begin
      pop = 4'd0;
      for (int i = 0; i < 8; i++)
         pop = pop + {3'd0, output_spikes_layer1[i]};
      act_sum = {1'b0, act} + {9'd0, pop};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         act            <= 12'd0;
         activity_count <= 12'd0;
      end else begin
         if (start)
            act <= 12'd0;
         else if (take)
            act <= act_sum[12] ? 12'hFFF : act_sum[11:0];
         if (state == DECIDE)
            activity_count <= act;
      end
   end
`else
   logic layer1_unused;
   assign layer1_unused = ^output_spikes_layer1;
`endif

endmodule

// File: tb/tb_kws_spike_decoder.sv
// Scoreboard bench for kws_spike_decoder: directed windows, monitor checks each decision.
// Activity checks compile in when DECODER_ACTIVITY_EN is defined.
module tb_kws_spike_decoder;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        spike_valid;
   logic [1:0]  output_spikes;
   logic [7:0]  output_spikes_layer1;
   logic [7:0]  window_len;
   logic [7:0]  min_count;
   logic        decision_ready;
   logic        decision_valid;
   logic [1:0]  decision_class;
   logic [7:0]  count0;
   logic [7:0]  count1;
   logic        busy;
   logic        overrun;
`ifdef DECODER_ACTIVITY_EN
   logic [11:0] activity_count;
`endif

   kws_spike_decoder dut (
      .clk                  (clk),
      .reset                (reset),
      .enable               (enable),
      .spike_valid          (spike_valid),
      .output_spikes        (output_spikes),
      .output_spikes_layer1 (output_spikes_layer1),
      .window_len           (window_len),
      .min_count            (min_count),
      .decision_ready       (decision_ready),
      .decision_valid       (decision_valid),
      .decision_class       (decision_class),
      .count0               (count0),
      .count1               (count1),
      .busy                 (busy),
`ifdef DECODER_ACTIVITY_EN
      .activity_count       (activity_count),
`endif
      .overrun              (overrun)
   );

   typedef struct packed {
      logic [1:0] cls;
      logic [7:0] c0;
      logic [7:0] c1;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   logic prev_v;
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pop on each new decision, then hold the outputs to it while valid.
   always @(negedge clk) begin
      if (decision_valid === 1'b1 && prev_v !== 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_decision actual=%0h/%0h/%0h required=none",
                     decision_class, count0, count1);
         end else begin
            cur = q.pop_front();
            if ({decision_class, count0, count1} !== cur) begin
               errors++;
               $display("FAIL decision actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                        decision_class, count0, count1, cur.cls, cur.c0, cur.c1);
            end
         end
      end else if (decision_valid === 1'b1) begin
         checks++;
         if ({decision_class, count0, count1} !== cur) begin
            errors++;
            $display("FAIL hold_stable actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                     decision_class, count0, count1, cur.cls, cur.c0, cur.c1);
         end
      end
      prev_v = decision_valid;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [1:0] sp, input logic [7:0] l1);
      spike_valid          = 1'b1;
      output_spikes        = sp;
      output_spikes_layer1 = l1;
      tick();
      spike_valid          = 1'b0;
   endtask

   task automatic start_win(input logic [7:0] wl, input logic [7:0] mc);
      window_len = wl;
      min_count  = mc;
      enable     = 1'b1;
      tick();
   endtask

   task automatic ack(input logic en);
      decision_ready = 1'b1;
      enable         = en;
      tick();
      decision_ready = 1'b0;
   endtask

   task automatic push(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.cls = c;
      e.c0  = a;
      e.c1  = b;
      q.push_back(e);
   endtask

   // Last sample already accepted: still in DECIDE now, valid after one more edge.
   task automatic finish_win(input string name);
      chk({name, "_decide"}, decision_valid, 1'b0);
      tick();
      chk({name, "_valid"}, decision_valid, 1'b1);
   endtask

   initial begin
      checks               = 0;
      errors               = 0;
      prev_v               = 1'b0;
      reset                = 1'b0;
      enable               = 1'b0;
      spike_valid          = 1'b0;
      output_spikes        = 2'b00;
      output_spikes_layer1 = 8'h00;
      window_len           = 8'd0;
      min_count            = 8'd0;
      decision_ready       = 1'b0;
      tick();
      tick();
      chk("rst_valid", decision_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_class", decision_class, 2'b00);
      chk("rst_counts", {count0, count1}, 16'h0000);
      chk("rst_overrun", overrun, 1'b0);
      reset = 1'b1;

      start_win(8'd4, 8'd2);
      chk("busy_accum", busy, 1'b1);
      push(2'b01, 8'd4, 8'd0);
      for (int i = 0; i < 4; i++) sample(2'b01, 8'h00);
      finish_win("w4");

      window_len = 8'd3;
      min_count  = 8'd1;
      ack(1'b1);
      chk("ack_drop", decision_valid, 1'b0);
      chk("ack_busy", busy, 1'b1);
      push(2'b11, 8'd2, 8'd2);
      sample(2'b11, 8'h00);
      sample(2'b11, 8'h00);
      sample(2'b00, 8'h00);
      finish_win("tie");
      ack(1'b0);
      chk("ack_idle", busy, 1'b0);

      start_win(8'd0, 8'd1);
      push(2'b10, 8'd0, 8'd255);
      for (int i = 0; i < 256; i++) sample(2'b10, 8'h00);
      finish_win("w256");
      chk("overrun_clear", overrun, 1'b0);

      for (int i = 0; i < 10; i++) begin
         spike_valid   = (i == 3);
         output_spikes = 2'b11;
         tick();
      end
      spike_valid = 1'b0;
      chk("overrun_set", overrun, 1'b1);
      chk("hold_valid", decision_valid, 1'b1);

      window_len = 8'd2;
      min_count  = 8'd2;
      ack(1'b1);
      chk("restart_drop", decision_valid, 1'b0);
      chk("restart_busy", busy, 1'b1);
      push(2'b01, 8'd2, 8'd1);
      sample(2'b01, 8'h00);
      tick();
      sample(2'b11, 8'h00);
      finish_win("gap");

      window_len = 8'd2;
      min_count  = 8'd0;
      ack(1'b1);
      push(2'b00, 8'd0, 8'd0);
      sample(2'b00, 8'h00);
      sample(2'b00, 8'h00);
      finish_win("zero_tie");

      window_len = 8'd3;
      min_count  = 8'd3;
      ack(1'b1);
      push(2'b00, 8'd0, 8'd2);
      sample(2'b10, 8'h00);
      sample(2'b10, 8'h00);
      sample(2'b00, 8'h00);
      finish_win("below_min");

      window_len = 8'd5;
      min_count  = 8'd1;
      ack(1'b1);
      sample(2'b01, 8'h00);
      sample(2'b01, 8'h00);
      enable = 1'b0;
      tick();
      chk("abort_idle", busy, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      chk("abort_no_valid", decision_valid, 1'b0);

      start_win(8'd2, 8'd3);
      push(2'b00, 8'd2, 8'd0);
      sample(2'b01, 8'hFF);
      sample(2'b01, 8'h0F);
      finish_win("reenable");
`ifdef DECODER_ACTIVITY_EN
      chk("activity", activity_count, 12'd12);
`endif
      chk("overrun_sticky", overrun, 1'b1);

      reset = 1'b0;
      tick();
      chk("hold_rst_valid", decision_valid, 1'b0);
      chk("hold_rst_busy", busy, 1'b0);
      chk("hold_rst_class", decision_class, 2'b00);
      chk("hold_rst_counts", {count0, count1}, 16'h0000);
      chk("hold_rst_overrun", overrun, 1'b0);
`ifdef DECODER_ACTIVITY_EN
      chk("hold_rst_activity", activity_count, 12'd0);
`endif
      reset  = 1'b1;
      enable = 1'b0;
      tick();
      tick();
      chk("scoreboard_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
